alu_seq: RTL and testbench

Parametrised sequential ALU: the next-generation arithmetic unit of the microcontroller datapath. It keeps the 16 existing single-cycle operations and adds add/subtract-with-carry, an iterative multiply and an iterative unsigned divide. Results and flags are registered, and a valid/ready handshake lets the control unit stall on multi-cycle operations.

---
 rtl/alu_seq.sv | 238 +++++++++++++++++++++++
 tb/tb_alu_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with registered result and flags.
// Single-cycle operations complete on the acceptance edge. MUL uses
// iterative shift-add and DIV uses iterative restoring division; both take
// WIDTH enabled cycles. A valid/ready handshake lets the controller stall.
//
// Ports:
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_enable                clock enable; low pauses everything except o_valid clear
//   i_valid / o_ready       request handshake, accepted when both high
//   i_mode                  operation select (0..19, 20..31 pass B)
//   i_operand1, i_operand2  operands A and B
//   i_cflags                incoming {Z,C,S,O}; only C is consumed
//   o_valid                 one-cycle pulse when a new result is presented
//   o_out, o_out_hi         result low half/quotient, high half/remainder
//   o_flags                 {Z,C,S,O} of the last result
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [4:0]       i_mode,
  input  logic [WIDTH-1:0] i_operand1,
  input  logic [WIDTH-1:0] i_operand2,
  input  logic [3:0]       i_cflags,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_out,
  output logic [WIDTH-1:0] o_out_hi,
  output logic [3:0]       o_flags
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             isDiv_q, isDiv_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] outHi_q, outHi_d;
  logic [3:0]       flags_q, flags_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] a, b;
  logic [SW-1:0]    n;
  logic [SW:0]      nInv;
  logic             unusedCflags;

  assign a            = i_operand1;
  assign b            = i_operand2;
  assign n            = a[SW-1:0];
  assign nInv         = (SW+1)'(WIDTH) - {1'b0, n};
  assign unusedCflags = ^{i_cflags[3], i_cflags[1:0]};

  // Shift/rotate datapaths. The extra bit on each shifter catches the last
  // bit shifted out, which naturally reads 0 when the amount is zero.
  logic [WIDTH-1:0]        rotl, rotr;
  logic [WIDTH:0]          shlWide, shrWide;
  logic signed [WIDTH:0]   sarWide;

  assign rotl    = (b << n) | (b >> nInv);
  assign rotr    = (b >> n) | (b << nInv);
  assign shlWide = {1'b0, b} << n;
  assign shrWide = {b, 1'b0} >> n;
  assign sarWide = $signed({b, 1'b0}) >>> n;

  // One shared adder serves every add and subtract mode. Subtraction is
  // x + ~y + cin, so carry-out directly means "no borrow".
  logic [WIDTH-1:0] addX, addY;
  logic             addCin;
  logic [WIDTH:0]   addSum;
  logic             addOvf;

  always_comb begin
    addX   = a;
    addY   = b;
    addCin = 1'b0;
    case (i_mode)
      5'd1:  begin addY = ~b;                addCin = 1'b1;        end
      5'd7:  begin addX = b;  addY = ~a;     addCin = 1'b1;        end
      5'd8:  begin addX = b;  addY = '0;     addCin = 1'b1;        end
      5'd9:  begin addX = b;  addY = ~ONE;   addCin = 1'b1;        end
      5'd15: begin addX = '0; addY = ~b;     addCin = 1'b1;        end
      5'd16: begin                           addCin = i_cflags[2]; end
      5'd17: begin addY = ~b;                addCin = i_cflags[2]; end
      default: ;
    endcase
    addSum = {1'b0, addX} + {1'b0, addY} + {{WIDTH{1'b0}}, addCin};
    addOvf = (addX[WIDTH-1] == addY[WIDTH-1]) && (addSum[WIDTH-1] != addX[WIDTH-1]);
  end

  logic [WIDTH-1:0] aluRes;
  logic             aluC, aluO;

  always_comb begin
    aluRes = b;
    aluC   = 1'b0;
    aluO   = 1'b0;
    case (i_mode)
      5'd0, 5'd1, 5'd7, 5'd8, 5'd9, 5'd15, 5'd16, 5'd17: begin
        aluRes = addSum[WIDTH-1:0];
        aluC   = addSum[WIDTH];
        aluO   = addOvf;
      end
      5'd2:  aluRes = a;
      5'd4:  aluRes = a & b;
      5'd5:  aluRes = a | b;
      5'd6:  aluRes = a ^ b;
      // After a rotate the final bit carried out lands at the wrap-in end.
      5'd10: begin aluRes = rotl; aluC = (n != '0) && rotl[0];       end
      5'd11: begin aluRes = rotr; aluC = (n != '0) && rotr[WIDTH-1]; end
      5'd12: begin aluRes = shlWide[WIDTH-1:0]; aluC = shlWide[WIDTH]; end
      5'd13: begin aluRes = shrWide[WIDTH:1];   aluC = shrWide[0];     end
      5'd14: begin aluRes = sarWide[WIDTH:1];   aluC = sarWide[0];     end
      default: aluRes = b;
    endcase
  end

  // One iteration step. MUL keeps {hi,lo} as partial product / multiplier.
  // DIV keeps hi as partial remainder and shifts quotient bits into lo; a
  // zero divisor always "fits", yielding all-ones quotient and remainder A.
  logic [WIDTH:0]   mulSum, divShift;
  logic [WIDTH-1:0] divSub;
  logic             divGe;
  logic [WIDTH-1:0] stepHi, stepLo;

  assign mulSum   = {1'b0, hi_q} + {1'b0, opB_q};
  assign divShift = {hi_q, lo_q[WIDTH-1]};
  assign divGe    = divShift >= {1'b0, opB_q};
  assign divSub   = divShift[WIDTH-1:0] - opB_q;

  always_comb begin
    stepHi = hi_q;
    stepLo = lo_q;
    if (isDiv_q) begin
      stepHi = divGe ? divSub : divShift[WIDTH-1:0];
      stepLo = {lo_q[WIDTH-2:0], divGe};
    end else if (lo_q[0]) begin
      {stepHi, stepLo} = {mulSum, lo_q[WIDTH-1:1]};
    end else begin
      {stepHi, stepLo} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
    end
  end

  // Control: accept in IDLE, iterate in BUSY. o_valid is never held over,
  // so its next value defaults to 0 regardless of the enable.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    isDiv_d = isDiv_q;
    opB_d   = opB_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    out_d   = out_q;
    outHi_d = outHi_q;
    flags_d = flags_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_enable && i_valid) begin
          if (i_mode == 5'd18 || i_mode == 5'd19) begin
            hi_d    = '0;
            lo_d    = a;
            opB_d   = b;
            isDiv_d = (i_mode == 5'd19);
            cnt_d   = CW'(WIDTH);
            state_d = BUSY;
          end else begin
            out_d   = aluRes;
            outHi_d = '0;
            flags_d = {aluRes == '0, aluC, aluRes[WIDTH-1], aluO};
            valid_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (i_enable) begin
          hi_d  = stepHi;
          lo_d  = stepLo;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
            valid_d = 1'b1;
            out_d   = stepLo;
            outHi_d = stepHi;
            if (isDiv_q)
              flags_d = {stepLo == '0, 1'b0, stepLo[WIDTH-1], opB_q == '0};
            else
              flags_d = {{stepHi, stepLo} == '0, 1'b0, stepLo[WIDTH-1], stepHi != '0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      isDiv_q <= 1'b0;
      opB_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      out_q   <= '0;
      outHi_q <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      isDiv_q <= isDiv_d;
      opB_q   <= opB_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      out_q   <= out_d;
      outHi_q <= outHi_d;
      flags_q <= flags_d;
      valid_q <= valid_d;
    end
  end

  assign o_ready  = (state_q == IDLE) && i_enable;
  assign o_valid  = valid_q;
  assign o_out    = out_q;
  assign o_out_hi = outHi_q;
  assign o_flags  = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq at WIDTH=8.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_alu_seq;

  localparam int W = 8;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_enable;
  logic         i_valid;
  logic         o_ready;
  logic [4:0]   i_mode;
  logic [W-1:0] i_operand1, i_operand2;
  logic [3:0]   i_cflags;
  logic         o_valid;
  logic [W-1:0] o_out, o_out_hi;
  logic [3:0]   o_flags;

  int compared   = 0;
  int mismatched = 0;

  alu_seq #(.WIDTH(W)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_enable   (i_enable),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_mode     (i_mode),
    .i_operand1 (i_operand1),
    .i_operand2 (i_operand2),
    .i_cflags   (i_cflags),
    .o_valid    (o_valid),
    .o_out      (o_out),
    .o_out_hi   (o_out_hi),
    .o_flags    (o_flags)
  );

  // Free-running 10-time-unit clock.
  always #5 i_clk = ~i_clk;

  // One comparison with an immediate assertion; failures are counted.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Issue one request and wait (bounded) for its o_valid. lat counts
  // falling edges after the acceptance edge; lowCnt counts o_ready low.
  task automatic applyStimulus(input logic [4:0] mode, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [3:0] cf,
                               output int lat, output int lowCnt);
    @(negedge i_clk);
    i_mode     = mode;
    i_operand1 = a;
    i_operand2 = b;
    i_cflags   = cf;
    i_valid    = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    lat     = 1;
    lowCnt  = 0;
    while (o_valid !== 1'b1 && lat < 40) begin
      if (o_ready === 1'b0) lowCnt++;
      @(negedge i_clk);
      lat++;
    end
  endtask

  initial begin
    int lat, lowCnt, cyc, gotAt, seen;
    i_rst_n    = 1'b0;
    i_enable   = 1'b1;
    i_valid    = 1'b0;
    i_mode     = '0;
    i_operand1 = '0;
    i_operand2 = '0;
    i_cflags   = '0;

    // Reset state
    @(negedge i_clk);
    @(negedge i_clk);
    checkOutput("rst_out",    32'(o_out),    'h0);
    checkOutput("rst_out_hi", 32'(o_out_hi), 'h0);
    checkOutput("rst_flags",  32'(o_flags),  'h0);
    checkOutput("rst_valid",  32'(o_valid),  'h0);
    checkOutput("rst_ready",  32'(o_ready),  'h1);
    i_enable = 1'b0;
    #1;
    checkOutput("rst_ready_dis", 32'(o_ready), 'h0);
    i_enable = 1'b1;
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // ADD with signed overflow
    applyStimulus(5'd0, 8'h7F, 8'h01, 4'b0000, lat, lowCnt);
    checkOutput("add_lat",    32'(lat),      'd1);
    checkOutput("add_out",    32'(o_out),    'h80);
    checkOutput("add_flags",  32'(o_flags),  'b0011);
    checkOutput("add_out_hi", 32'(o_out_hi), 'h0);
    @(negedge i_clk);
    checkOutput("add_pulse", 32'(o_valid), 'h0);
    checkOutput("add_hold",  32'(o_out),   'h80);

    // SUB equal operands
    applyStimulus(5'd1, 8'h05, 8'h05, 4'b0000, lat, lowCnt);
    checkOutput("sub_out",   32'(o_out),   'h00);
    checkOutput("sub_flags", 32'(o_flags), 'b1100);

    // ADC / SBC using incoming carry
    applyStimulus(5'd16, 8'hFF, 8'h00, 4'b0100, lat, lowCnt);
    checkOutput("adc_out",   32'(o_out),   'h00);
    checkOutput("adc_flags", 32'(o_flags), 'b1100);
    applyStimulus(5'd17, 8'h10, 8'h01, 4'b0000, lat, lowCnt);
    checkOutput("sbc_out",   32'(o_out),   'h0E);
    checkOutput("sbc_flags", 32'(o_flags), 'b0100);

    // Negate zero: no borrow, so C=1
    applyStimulus(5'd15, 8'h33, 8'h00, 4'b0000, lat, lowCnt);
    checkOutput("neg0_out",   32'(o_out),   'h00);
    checkOutput("neg0_flags", 32'(o_flags), 'b1100);

    // Shifts and rotates
    applyStimulus(5'd10, 8'h01, 8'h81, 4'b0000, lat, lowCnt);
    checkOutput("rol_out",   32'(o_out),   'h03);
    checkOutput("rol_flags", 32'(o_flags), 'b0100);
    applyStimulus(5'd14, 8'h03, 8'h80, 4'b0000, lat, lowCnt);
    checkOutput("sar_out",   32'(o_out),   'hF0);
    checkOutput("sar_flags", 32'(o_flags), 'b0010);
    applyStimulus(5'd12, 8'h00, 8'hA5, 4'b0000, lat, lowCnt);
    checkOutput("shl0_out",   32'(o_out),   'hA5);
    checkOutput("shl0_flags", 32'(o_flags), 'b0010);
    applyStimulus(5'd13, 8'h04, 8'h9C, 4'b0000, lat, lowCnt);
    checkOutput("shr_out",   32'(o_out),   'h09);
    checkOutput("shr_flags", 32'(o_flags), 'b0100);

    // Unused mode passes B
    applyStimulus(5'd25, 8'h12, 8'h00, 4'b0000, lat, lowCnt);
    checkOutput("mode25_out",   32'(o_out),   'h00);
    checkOutput("mode25_flags", 32'(o_flags), 'b1000);

    // Back-to-back accepts keep o_valid high
    @(negedge i_clk);
    i_mode = 5'd0; i_operand1 = 8'h01; i_operand2 = 8'h02; i_valid = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("b2b_valid1", 32'(o_valid), 'h1);
    checkOutput("b2b_out1",   32'(o_out),   'h03);
    i_mode = 5'd4; i_operand1 = 8'hF0; i_operand2 = 8'h3C;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    checkOutput("b2b_valid2", 32'(o_valid), 'h1);
    checkOutput("b2b_out2",   32'(o_out),   'h30);

    // MUL
    applyStimulus(5'd18, 8'h0F, 8'h11, 4'b0000, lat, lowCnt);
    checkOutput("mul1_lat",    32'(lat),      'd9);
    checkOutput("mul1_ready",  32'(lowCnt),   'd8);
    checkOutput("mul1_out",    32'(o_out),    'hFF);
    checkOutput("mul1_out_hi", 32'(o_out_hi), 'h00);
    checkOutput("mul1_flags",  32'(o_flags),  'b0010);
    applyStimulus(5'd18, 8'h10, 8'h10, 4'b0000, lat, lowCnt);
    checkOutput("mul2_lat",    32'(lat),      'd9);
    checkOutput("mul2_ready",  32'(lowCnt),   'd8);
    checkOutput("mul2_out",    32'(o_out),    'h00);
    checkOutput("mul2_out_hi", 32'(o_out_hi), 'h01);
    checkOutput("mul2_flags",  32'(o_flags),  'b0001);

    // DIV, including divide by zero
    applyStimulus(5'd19, 8'h64, 8'h07, 4'b0000, lat, lowCnt);
    checkOutput("div_lat",    32'(lat),      'd9);
    checkOutput("div_out",    32'(o_out),    'h0E);
    checkOutput("div_out_hi", 32'(o_out_hi), 'h02);
    checkOutput("div_flags",  32'(o_flags),  'b0000);
    applyStimulus(5'd19, 8'h64, 8'h00, 4'b0000, lat, lowCnt);
    checkOutput("div0_lat",    32'(lat),      'd9);
    checkOutput("div0_out",    32'(o_out),    'hFF);
    checkOutput("div0_out_hi", 32'(o_out_hi), 'h64);
    checkOutput("div0_flags",  32'(o_flags),  'b0011);

    // MUL with i_enable low for three cycles mid-operation
    @(negedge i_clk);
    i_mode = 5'd18; i_operand1 = 8'h0F; i_operand2 = 8'h11; i_valid = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    i_operand1 = 8'h00;
    cyc   = 1;
    gotAt = 0;
    while (cyc < 40 && gotAt == 0) begin
      if (o_valid === 1'b1) gotAt = cyc;
      else begin
        if (cyc == 3) i_enable = 1'b0;
        if (cyc == 6) i_enable = 1'b1;
        @(negedge i_clk);
        cyc++;
      end
    end
    i_enable = 1'b1;
    checkOutput("stall_lat",    32'(gotAt),    'd12);
    checkOutput("stall_out",    32'(o_out),    'hFF);
    checkOutput("stall_out_hi", 32'(o_out_hi), 'h00);

    // Reset pulse mid-BUSY aborts with no o_valid
    @(negedge i_clk);
    i_mode = 5'd18; i_operand1 = 8'h10; i_operand2 = 8'h10; i_valid = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    for (int k = 1; k < 4; k++) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    checkOutput("abort_out",    32'(o_out),    'h0);
    checkOutput("abort_out_hi", 32'(o_out_hi), 'h0);
    checkOutput("abort_flags",  32'(o_flags),  'h0);
    checkOutput("abort_valid",  32'(o_valid),  'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    checkOutput("abort_ready", 32'(o_ready), 'h1);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge i_clk);
      if (o_valid === 1'b1) seen++;
    end
    checkOutput("abort_no_valid", 32'(seen),  'd0);
    checkOutput("abort_out_end",  32'(o_out), 'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
